// File: rtl/fp12_pkg.sv
// Shared fp12 types, constants and the arbiter tag carried alongside the adder pipeline.
package fp12_pkg;

    localparam int unsigned FP12_W   = 12;
    localparam int unsigned ARB_ID_W = 3;

    typedef struct packed {
        logic       sgn;
        logic [4:0] exp;
        logic [5:0] man;
    } fp12_t;

    localparam logic [FP12_W-1:0] FP12_ONE = 12'h3C0;
    localparam logic [FP12_W-1:0] FP12_TWO = 12'h400;

    // id is sized for the largest supported requester count
    typedef struct packed {
        logic                valid;
        logic [ARB_ID_W-1:0] id;
    } arb_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] eligible,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt_ptr;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant   = '0;
        nxt_ptr = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                nxt_ptr    = PW'((32'(idx) + 32'd1) % N);
            end
        end
    end

    // pointer moves past the winner only when a grant is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= nxt_ptr;
        end
    end

endmodule

// File: rtl/fp12_add_arbiter.sv
// Shares one pipelined fp12 adder among N_REQ requesters and routes sums back by tag.
// Optional perf counters enabled with `define FP12_ARB_PERF_CNT_EN.
module fp12_add_arbiter
    import fp12_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADD_LAT = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [FP12_W*N_REQ-1:0] req_a_i,
    input  logic [FP12_W*N_REQ-1:0] req_b_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [FP12_W-1:0]       rsp_data_o,
    output logic [FP12_W-1:0]       add_a_o,
    output logic [FP12_W-1:0]       add_b_o,
    input  logic [FP12_W-1:0]       add_sum_i,
    output logic                    busy_o
`ifdef FP12_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_issue_o,
    output logic [31:0]             perf_stall_o
`endif
);

    localparam int unsigned DEPTH = ADD_LAT + 1;
    localparam int unsigned CNT_W = 4;

    arb_tag_t            tags [DEPTH];
    arb_tag_t            tail;
    logic [CNT_W-1:0]    cnt  [N_REQ];
    logic [N_REQ-1:0]    retire;
    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    grant;
    logic                issue;
    logic                any_cnt;
    logic [FP12_W-1:0]   win_a;
    logic [FP12_W-1:0]   win_b;
    logic [ARB_ID_W-1:0] win_id;

    assign tail        = tags[DEPTH-1];
    assign issue       = |grant;
    assign req_ready_o = grant;

    // a retiring requester frees its slot in the same cycle, so it may re-issue at the limit
    always_comb begin
        retire   = '0;
        eligible = '0;
        any_cnt  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            retire[i]   = tail.valid && (tail.id == ARB_ID_W'(i));
            eligible[i] = req_valid_i[i] && !rst_i &&
                          ((cnt[i] < CNT_W'(MAX_OUT)) || retire[i]);
            any_cnt     = any_cnt || (cnt[i] != '0);
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk      (clk_i),
        .rst      (rst_i),
        .eligible (eligible),
        .advance  (issue),
        .grant    (grant)
    );

    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_a  = req_a_i[i*FP12_W +: FP12_W];
                win_b  = req_b_i[i*FP12_W +: FP12_W];
                win_id = ARB_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            add_a_o     <= '0;
            add_b_o     <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) tags[k] <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            if (issue) begin
                add_a_o <= win_a;
                add_b_o <= win_b;
            end
            tags[0] <= '{valid: issue, id: win_id};
            for (int unsigned k = 1; k < DEPTH; k++) tags[k] <= tags[k-1];
            rsp_valid_o <= retire;
            if (tail.valid) rsp_data_o <= add_sum_i;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] && !retire[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (!grant[i] && retire[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
            busy_o <= any_cnt;
        end
    end

`ifdef FP12_ARB_PERF_CNT_EN
    // a stall is any valid requester left without a grant this cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issue_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (issue) perf_issue_o <= perf_issue_o + 32'd1;
            if (|(req_valid_i & ~grant)) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp12_add_arbiter.sv
// Scoreboard bench for fp12_add_arbiter with a behavioural pipelined adder.
// Perf counter checks are compiled in when FP12_ARB_PERF_CNT_EN is defined.
module tb_fp12_add_arbiter;
    import fp12_pkg::*;

    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 4;
    localparam int unsigned MO  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [12*NR-1:0] req_a = '0;
    logic [12*NR-1:0] req_b = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [11:0]     rsp_data;
    logic [11:0]     add_a;
    logic [11:0]     add_b;
    logic [11:0]     add_sum;
    logic            busy;
`ifdef FP12_ARB_PERF_CNT_EN
    logic [31:0]     perf_issue;
    logic [31:0]     perf_stall;
`endif

    fp12_add_arbiter #(
        .N_REQ   (NR),
        .ADD_LAT (LAT),
        .MAX_OUT (MO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_sum_i   (add_sum),
`ifdef FP12_ARB_PERF_CNT_EN
        .perf_issue_o(perf_issue),
        .perf_stall_o(perf_stall),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // positive normal operands only; truncating alignment and normalisation
    function automatic logic [11:0] fp_add(input logic [11:0] a, input logic [11:0] b);
        logic [4:0] ea, eb, e, d;
        logic [7:0] ma, mb, s;
        ea = a[10:6];
        eb = b[10:6];
        ma = {2'b01, a[5:0]};
        mb = {2'b01, b[5:0]};
        if (eb > ea) begin
            e = ea; ea = eb; eb = e;
            s = ma; ma = mb; mb = s;
        end
        d  = ea - eb;
        mb = mb >> d;
        s  = ma + mb;
        e  = ea;
        if (s[7]) begin
            s = s >> 1;
            e = e + 5'd1;
        end
        return {1'b0, e, s[5:0]};
    endfunction

    // behavioural add_12: LAT edges from registered operands to sum
    logic [11:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= fp_add(add_a, add_b);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum = apipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [11:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // scoreboard: push on handshake, pop and compare on response
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_id", 32'(rsp_valid), 32'd1 << mon_e.id);
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                chk("rsp_lat", 32'(cyc), 32'(mon_e.due));
            end
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            mon_e = sbq.pop_front();
            chk("rsp_missing", 32'(rsp_valid), 32'd1 << mon_e.id);
        end
        if (rst) begin
            sbq.delete();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sbq.push_back('{id: i, data: fp_add(req_a[i*12 +: 12], req_b[i*12 +: 12]),
                                    due: cyc + LAT + 2});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        req_a[i*12 +: 12] = a;
        req_b[i*12 +: 12] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          h;
    logic [11:0] pat;

    initial begin
        // reset state and single op
        do_reset();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        tick();
        set_op(0, FP12_ONE, FP12_ONE);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        h = cyc;
        tick();
        req_valid = '0;
        while (cyc < h + LAT + 2) tick();
        @(negedge clk);
        chk("single_rsp", 32'(rsp_valid), 32'h1);
        chk("single_sum", 32'(rsp_data), 32'(FP12_TWO));
        chk("single_busy_hi", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        chk("single_busy_lo", 32'(busy), 32'd0);
        chk("single_pulse", 32'(rsp_valid), 32'd0);
        tick();

        // full contention from a fresh pointer
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 12'h3C0 + 12'(i * 32), 12'h3C0 + 12'(i * 16));
        set_op(1, 12'h3E0, 12'h3E0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("cont_grant", 32'(req_ready), 32'd1 << (k % 4));
`ifdef FP12_ARB_PERF_CNT_EN
            if (k == 0) begin
                chk("perf_issue_rst", perf_issue, 32'd0);
                chk("perf_stall_rst", perf_stall, 32'd0);
            end
`endif
            tick();
        end
        req_valid = '0;
`ifdef FP12_ARB_PERF_CNT_EN
        @(negedge clk);
        chk("perf_issue", perf_issue, 32'd8);
        chk("perf_stall", perf_stall, 32'd8);
`endif
        repeat (12) tick();
        chk("cont_drain", 32'(sbq.size()), 32'd0);
        chk("cont_busy", 32'(busy), 32'd0);

        // outstanding limit on a lone requester
        set_op(2, 12'h410, 12'h3C8);
        req_valid = 4'b0100;
        pat = 12'b110001100011;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("limit_ready", 32'(req_ready[2]), 32'(pat[k]));
            tick();
        end
        req_valid = '0;
        repeat (12) tick();
        chk("limit_drain", 32'(sbq.size()), 32'd0);

        // pointer hold and wrap
        set_op(0, 12'h3D0, 12'h3C0);
        set_op(3, 12'h3F0, 12'h3E0);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("ptr_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        chk("ptr_grant0", 32'(req_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("ptr_grant3b", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        repeat (12) tick();
        chk("ptr_drain", 32'(sbq.size()), 32'd0);

        // reset with three operations in flight
        set_op(0, 12'h3C0, 12'h3C0);
        set_op(1, 12'h400, 12'h3C0);
        set_op(2, 12'h3E0, 12'h3D0);
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_grant", 32'(req_ready), 32'd1 << k);
            tick();
        end
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_op(1, 12'h3E0, 12'h3E0);
        req_valid = 4'b0010;
        pat = 12'b000000000011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_cnt_ready", 32'(req_ready[1]), 32'(pat[k]));
            tick();
        end
        req_valid = '0;
        repeat (12) tick();
        chk("mid_drain", 32'(sbq.size()), 32'd0);
        chk("mid_busy_end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fp12_add_arbiter.md
Name: fp12_add_arbiter

Overview:
Shares one pipelined 12-bit float adder (add_12) among N requesters. Per-requester valid/ready operand channels are arbitrated round-robin, and the winner's operands are registered onto the adder inputs. A tag pipeline that matches the adder depth routes each sum back to its originator. Sits between the neuron accumulation engines and a single add_12 instance at the processing-element top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADD_LAT, 4, add_12 latency in clk_i edges from registered operands to data_sum_o
MAX_OUT, 4, max in-flight operations per requester (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  N_REQ  operand pair valid, per requester
req_a_i  in  12*N_REQ  operand A, requester i at [12i+11:12i]; fp12 = sign[11], exp[10:6] bias 15, man[5:0]
req_b_i  in  12*N_REQ  operand B, same packing
req_ready_o  out  N_REQ  handshake accept, one-hot or zero
rsp_valid_o  out  N_REQ  one-hot result strobe
rsp_data_o  out  12  result, shared by all requesters
add_a_o  out  12  to add_12 data_1_i
add_b_o  out  12  to add_12 data_2_i
add_sum_i  in  12  from add_12 data_sum_o
busy_o  out  1  any operation in flight

Behaviour:
- Reset (synchronous, rst_i=1 at an edge): add_a_o/add_b_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0, RR pointer=0, outstanding counters=0, tag pipe cleared. Operations in flight are dropped; adder outputs arriving afterwards are ignored because their tags are cleared.
- Eligibility: eligible[i] = req_valid_i[i] & (cnt[i] < MAX_OUT | retire[i]). retire[i] means the tag at the pipe tail is valid for i, so that response is delivered this cycle.
- Grant: the first eligible index at or after the RR pointer, wrapping. req_ready_o = one-hot of the granted index, combinational. The handshake is req_valid_i[i] & req_ready_o[i]. At most one grant per cycle.
- Pointer: after a grant to i, the pointer becomes (i+1) mod N_REQ. With no grant, the pointer holds.
- Issue: on the handshake edge, add_a_o/add_b_o register the winner's operands and {valid=1, id=i} enters stage 0 of the tag pipe. With no handshake, add_a_o/add_b_o hold their value and a bubble (valid=0) enters.
- Tag pipe depth is ADD_LAT+1. The tail aligns with add_sum_i for that issue.
- Response: when the tail is valid, rsp_valid_o[id] and rsp_data_o <= add_sum_i are registered.
  - End-to-end latency: rsp_valid_o is high exactly ADD_LAT+2 cycles after the handshake cycle.
  - There is no response backpressure; the requester must sink it.
- Counters: cnt[i] increments on handshake of i and decrements on retire of i. Both in the same cycle leave it unchanged. The counter never exceeds MAX_OUT and never underflows.
- rsp_valid_o pulses exactly one cycle per operation. rsp_data_o holds its last value when no response is presented.
- busy_o is registered: high when any cnt[i] is nonzero.
- A requester may drop req_valid_i without a handshake; operands are sampled only on the handshake edge.
- Throughput: one issue per cycle sustained, provided the granted requester is below MAX_OUT.

Optional Feature:
FP12_ARB_PERF_CNT_EN
- Defined: adds outputs perf_issue_o[31:0] and perf_stall_o[31:0].
  - perf_issue_o counts handshakes.
  - perf_stall_o counts cycles where |req_valid_i is high but no grant happened, or a valid requester other than the winner was left waiting.
  - Both counters reset to 0 on rst_i and wrap at 2^32.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package fp12_pkg:
  - typedef fp12_t (12-bit packed struct: sgn, exp[4:0], man[5:0]);
  - constants FP12_ONE=12'h3C0, FP12_TWO=12'h400;
  - typedef arb_tag_t {valid, id[$clog2(N_REQ)-1:0]}.
- One sub-module, rr_arbiter: parameterised N, inputs eligible and advance, outputs the one-hot grant; it holds the pointer.
- Tag pipe and counters stay in fp12_add_arbiter.

Test Plan:
- Single op: rst_i high for 2 cycles. Requester 0 sends A=12'h3C0, B=12'h3C0, with an add_12 model of ADD_LAT=4 -> rsp_valid_o=4'b0001 and rsp_data_o=12'h400 exactly 6 cycles after the handshake; busy_o falls the cycle after.
- Full contention: all 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3. Each response lands on the matching id, e.g. 12'h3E0+12'h3E0 -> 12'h420.
- Outstanding limit: MAX_OUT=2, requester 2 alone, valid constantly -> 2 handshakes, then req_ready_o[2]=0 until its first response cycle. In that cycle the re-grant happens (simultaneous retire+issue) and cnt stays 2.
- Pointer hold: only requester 3 valid, then requesters 0 and 3 valid -> grant 3, then 0 (pointer wrapped to 0), then 3.
- Reset mid-operation: 3 ops in flight, rst_i pulsed 1 cycle -> no rsp_valid_o for the dropped ops, cnt=0, busy_o=0. A new op afterwards completes with the correct latency.
- FP12_ARB_PERF_CNT_EN: 4 requesters valid for 8 cycles -> perf_issue_o=8 and perf_stall_o=8. Reset -> both 0.
